// File: rtl/byte_demux2.sv
// byte_demux2: steers each accepted input byte into one of two independent 2-deep FIFO channels.
// Optional per-channel delivery counters (cnt0/cnt1) are built only when macro DEMUX_CNT_EN is defined.
module byte_demux2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    logic [WIDTH-1:0] r_mem0 [0:1];
    logic [WIDTH-1:0] r_mem1 [0:1];
    logic             r_rptr0, r_wptr0, r_rptr1, r_wptr1;
    logic [1:0]       r_cnt0, r_cnt1;

    logic w_full0, w_full1;
    logic w_push0, w_push1;
    logic w_pop0, w_pop1;

    assign w_full0 = (r_cnt0 == 2'd2);
    assign w_full1 = (r_cnt1 == 2'd2);

    // Readiness looks only at the addressed channel, never at valid or downstream ready.
    assign in_ready = in_sel ? ~w_full1 : ~w_full0;

    assign w_push0 = in_valid & in_ready & ~in_sel & ~rst;
    assign w_push1 = in_valid & in_ready &  in_sel & ~rst;

    assign out0_valid = (r_cnt0 != 2'd0);
    assign out1_valid = (r_cnt1 != 2'd0);
    assign out0_data  = r_mem0[r_rptr0];
    assign out1_data  = r_mem1[r_rptr1];

    assign w_pop0 = out0_valid & out0_ready;
    assign w_pop1 = out1_valid & out1_ready;

    // Storage is deliberately left out of reset; valid masks stale entries.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_mem0[r_wptr0] <= in_data;
        end
        if (w_push1) begin
            r_mem1[r_wptr1] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr0 <= 1'b0;
            r_wptr0 <= 1'b0;
            r_cnt0  <= 2'd0;
        end else begin
            if (w_push0) begin
                r_wptr0 <= r_wptr0 + 1'b1;
            end
            if (w_pop0) begin
                r_rptr0 <= r_rptr0 + 1'b1;
            end
            case ({w_push0, w_pop0})
                2'b10:   r_cnt0 <= r_cnt0 + 2'd1;
                2'b01:   r_cnt0 <= r_cnt0 - 2'd1;
                default: r_cnt0 <= r_cnt0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr1 <= 1'b0;
            r_wptr1 <= 1'b0;
            r_cnt1  <= 2'd0;
        end else begin
            if (w_push1) begin
                r_wptr1 <= r_wptr1 + 1'b1;
            end
            if (w_pop1) begin
                r_rptr1 <= r_rptr1 + 1'b1;
            end
            case ({w_push1, w_pop1})
                2'b10:   r_cnt1 <= r_cnt1 + 2'd1;
                2'b01:   r_cnt1 <= r_cnt1 - 2'd1;
                default: r_cnt1 <= r_cnt1;
            endcase
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] r_del0, r_del1;

    // Delivery counters wrap naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_del0 <= 8'd0;
            r_del1 <= 8'd0;
        end else begin
            if (w_pop0) begin
                r_del0 <= r_del0 + 8'd1;
            end
            if (w_pop1) begin
                r_del1 <= r_del1 + 8'd1;
            end
        end
    end

    assign cnt0 = r_del0;
    assign cnt1 = r_del1;
`endif

endmodule

// File: tb/tb_byte_demux2.sv
// tb_byte_demux2: directed and randomized checks of byte_demux2 against a queue-based channel model.
// Build with +define+DEMUX_CNT_EN to also check the delivery counters.
module tb_byte_demux2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_sel = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out0_valid, out1_valid;
    logic       out0_ready = 1'b0;
    logic       out1_ready = 1'b0;
    logic [7:0] out0_data, out1_data;
`ifdef DEMUX_CNT_EN
    logic [7:0] cnt0, cnt1;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         m_del0 = 0;
    int         m_del1 = 0;

    byte_demux2 #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each channel is just an ordered queue of at most two bytes.
    always @(posedge clk) begin
        bit pop0, pop1, push0, push1;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_del0 = 0;
            m_del1 = 0;
        end else begin
            pop0  = (q0.size() != 0) && out0_ready;
            pop1  = (q1.size() != 0) && out1_ready;
            push0 = in_valid && !in_sel && (q0.size() < 2);
            push1 = in_valid &&  in_sel && (q1.size() < 2);
            if (pop0) begin
                void'(q0.pop_front());
                m_del0 = (m_del0 + 1) % 256;
            end
            if (pop1) begin
                void'(q1.pop_front());
                m_del1 = (m_del1 + 1) % 256;
            end
            if (push0) q0.push_back(in_data);
            if (push1) q1.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, ((in_sel ? q1.size() : q0.size()) < 2)});
            chk("out0_valid", {31'd0, out0_valid}, {31'd0, (q0.size() != 0)});
            chk("out1_valid", {31'd0, out1_valid}, {31'd0, (q1.size() != 0)});
            if (q0.size() != 0) chk("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
            if (q1.size() != 0) chk("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
`ifdef DEMUX_CNT_EN
            chk("cnt0", {24'd0, cnt0}, m_del0);
            chk("cnt1", {24'd0, cnt1}, m_del1);
`endif
        end
    end

    initial begin
        // Reset: in_ready reads 1 even while rst is high.
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        step();

        // Single push to channel 0, one-cycle latency.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("push_a5_valid0", {31'd0, out0_valid}, 32'd1);
        chk("push_a5_data0", {24'd0, out0_data}, 32'hA5);
        chk("push_a5_valid1", {31'd0, out1_valid}, 32'd0);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        chk("pop_a5_empty", {31'd0, out0_valid}, 32'd0);

        // Fill channel 1, check backpressure is per-channel.
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h11;
        step();
        in_data = 8'h22;
        step();
        chk("full1_in_ready", {31'd0, in_ready}, 32'd0);
        in_sel = 1'b0;
        #1;
        chk("sel0_in_ready", {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1; in_data = 8'h33;
        step();
        in_valid = 1'b0;
        chk("reject_33_head", {24'd0, out1_data}, 32'h11);
        out1_ready = 1'b1;
        #1;
        chk("drain1_first", {24'd0, out1_data}, 32'h11);
        step();
        chk("drain1_second", {24'd0, out1_data}, 32'h22);
        step();
        out1_ready = 1'b0;
        chk("drain1_empty", {31'd0, out1_valid}, 32'd0);

        // Simultaneous push and pop at count 1.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01;
        step();
        in_data = 8'h02; out0_ready = 1'b1;
        step();
        in_valid = 1'b0; out0_ready = 1'b0;
        chk("pushpop_valid", {31'd0, out0_valid}, 32'd1);
        chk("pushpop_data", {24'd0, out0_data}, 32'h02);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;
        chk("pushpop_count1", {31'd0, out0_valid}, 32'd0);

        // Alternating channels with free-flowing downstream.
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_sel = i[0]; in_data = 8'h10 + 8'(i);
            step();
            if (i[0]) begin
                chk("alt_out1_valid", {31'd0, out1_valid}, 32'd1);
                chk("alt_out1_data", {24'd0, out1_data}, 32'h10 + i);
            end else begin
                chk("alt_out0_valid", {31'd0, out0_valid}, 32'd1);
                chk("alt_out0_data", {24'd0, out0_data}, 32'h10 + i);
            end
        end
        in_valid = 1'b0;
        step();
        out0_ready = 1'b0; out1_ready = 1'b0;

        // Fill both channels, then reset with a byte in flight.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sel = i[0]; in_data = 8'hC0 + 8'(i);
            step();
        end
        rst = 1'b1; in_sel = 1'b0; in_data = 8'hEE;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_valid0", {31'd0, out0_valid}, 32'd0);
        chk("midrst_valid1", {31'd0, out1_valid}, 32'd0);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h5A;
        step();
        in_valid = 1'b0;
        chk("postrst_data0", {24'd0, out0_data}, 32'h5A);
        chk("postrst_valid0", {31'd0, out0_valid}, 32'd1);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0;

        // Randomized traffic with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(63) == 0);
            in_valid   = $urandom_range(1);
            in_sel     = $urandom_range(1);
            in_data    = 8'($urandom);
            out0_ready = ($urandom_range(3) != 0);
            out1_ready = ($urandom_range(2) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        step();

`ifdef DEMUX_CNT_EN
        // 257 deliveries on channel 0 wrap the counter to 1.
        rst = 1'b1;
        step();
        rst = 1'b0; out0_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1; in_sel = 1'b0; in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        step();
        out0_ready = 1'b0;
        chk("cnt0_wrap", {24'd0, cnt0}, 32'd1);
        chk("cnt1_idle", {24'd0, cnt1}, 32'd0);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/byte_demux2.md
BYTE_DEMUX2 -- requirements
Module: byte_demux2

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the data width of every data port.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream byte present.
REQ-005 Port: in_ready  output  1  block accepts the byte this cycle.
REQ-006 Port: in_sel  input  1  destination: 0 selects channel 0, 1 selects channel 1.
REQ-007 Port: in_data  input  WIDTH  upstream byte.
REQ-008 Port: out0_valid, out1_valid  output  1 each  channel holds a byte.
REQ-009 Port: out0_ready, out1_ready  input  1 each  downstream consumes the head byte.
REQ-010 Port: out0_data, out1_data  output  WIDTH each  channel head byte.
REQ-011 Port: cnt0, cnt1  output  8 each  bytes delivered per channel (present only under DEMUX_CNT_EN).

Function
REQ-012 Each channel SHALL contain a 2-entry FIFO with a read pointer, a write pointer and a 2-bit occupancy count (0..2).
REQ-013 in_ready SHALL equal NOT full of the channel named by in_sel, combinationally; it SHALL NOT depend on in_valid or on either outN_ready.
REQ-014 A push SHALL occur when in_valid and in_ready are both 1; in_data is written to the selected channel only; the other channel is untouched.
REQ-015 outN_valid SHALL be 1 exactly when channel N count is nonzero; outN_data SHALL be the entry at its read pointer.
REQ-016 A pop on channel N SHALL occur when outN_valid and outN_ready are both 1.
REQ-017 outN_data SHALL remain stable while outN_valid is 1 and outN_ready is 0.
REQ-018 Latency: a byte pushed in cycle t SHALL appear on outN_data with outN_valid=1 in cycle t+1 if the channel was empty.
REQ-019 Push and pop on the same channel in one cycle SHALL leave the count unchanged and preserve FIFO order; this is possible only at count 1 (at count 2 in_ready is 0).
REQ-020 Bytes SHALL leave each channel in the order they entered it; no ordering is enforced between channels.
REQ-021 Pointers SHALL wrap from 1 to 0.
REQ-022 outN_ready asserted while outN_valid is 0 SHALL have no effect.
REQ-023 Both channels SHALL pop independently in the same cycle.

Reset
REQ-024 While rst is 1 at a rising clk edge, all pointers and counts SHALL clear to 0, out0_valid and out1_valid SHALL be 0 the next cycle, and any in-flight byte SHALL be discarded.
REQ-025 During reset, in_ready SHALL follow REQ-013 (it reads 1), but no push SHALL take effect in a cycle with rst=1.
REQ-026 FIFO storage contents SHALL NOT be reset; outN_data is don't-care while outN_valid is 0.

Configuration
REQ-027 With macro DEMUX_CNT_EN defined, cnt0 and cnt1 SHALL exist; each increments by 1 on every pop of its channel, wraps 255 to 0, and resets to 0.
REQ-028 Without DEMUX_CNT_EN, cnt0, cnt1 and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 After reset, push 0xA5 with sel=0, out0_ready=0 -> next cycle out0_valid=1, out0_data=0xA5, out1_valid=0.
REQ-030 With out1_ready=0, push 0x11, 0x22 with sel=1 -> in_ready goes 0 for sel=1 and stays 1 for sel=0; a third push of 0x33 to sel=1 is not accepted; raising out1_ready yields 0x11 then 0x22.
REQ-031 At channel 0 count 1 (head 0x01), push 0x02 and pop in the same cycle -> count stays 1, out0_data=0x02 next cycle.
REQ-032 Alternate sel 0/1 with bytes 0x10..0x17 and both readies held at 1 -> out0 sees 0x10,0x12,0x14,0x16; out1 sees 0x11,0x13,0x15,0x17, each one cycle after its push.
REQ-033 Fill both channels, assert rst for one cycle mid-stream -> out0_valid=out1_valid=0 afterwards; the next push of 0x5A on sel=0 appears first on out0.
REQ-034 With DEMUX_CNT_EN, deliver 257 bytes on channel 0 -> cnt0=1, cnt1=0.
